// File: rtl/ecc_pkg.sv
// Shared SEC-DED definitions: modes, lengths, H-matrix columns and error classes.
// Codeword layout: bit 0 = overall parity, bits [P-1:1] = check bits, info above.
package ecc_pkg;

    localparam int CW_WIDTH   = 32;
    localparam int INFO_WIDTH = 26;
    localparam int SYN_WIDTH  = 5;
    localparam int POS_WIDTH  = 6;

    typedef enum logic [1:0] {
        MODE_8_4     = 2'b00,
        MODE_16_11   = 2'b01,
        MODE_32_26   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        CLS_CLEAN   = 2'd0,
        CLS_SINGLE  = 2'd1,
        CLS_DOUBLE  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } err_class_e;

    localparam int INFO_LEN [4] = '{4, 11, 26, 0};
    localparam int PAR_LEN  [4] = '{4, 5, 6, 0};
    localparam int FULL_LEN [4] = '{8, 16, 32, 0};

    // Info bit k uses the k-th non-power-of-two value; a prefix of this list serves every mode.
    localparam logic [SYN_WIDTH-1:0] INFO_COL [26] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13,
        5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
        5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31
    };

    // H-matrix column of codeword bit idx; the overall parity bit and unused bits have none.
    function automatic logic [SYN_WIDTH-1:0] h_col(input mode_e mode, input int idx);
        int plen;
        int flen;
        plen  = PAR_LEN[mode];
        flen  = FULL_LEN[mode];
        h_col = '0;
        if (idx >= 1 && idx < plen)
            h_col = SYN_WIDTH'(1 << (idx - 1));
        else if (idx >= plen && idx < flen)
            h_col = INFO_COL[idx - plen];
    endfunction

endpackage

// File: rtl/dec_syndrome.sv
// Combinational syndrome and overall parity of one codeword in a given mode.
module dec_syndrome
    import ecc_pkg::*;
(
    input  logic [CW_WIDTH-1:0]  codeword,
    input  mode_e                mode,
    output logic [SYN_WIDTH-1:0] s,
    output logic                 p
);

    logic [SYN_WIDTH-1:0] term [CW_WIDTH];
    logic [CW_WIDTH-1:0]  live;

    generate
        for (genvar gi = 0; gi < CW_WIDTH; gi++) begin : g_bit
            assign live[gi] = (gi < FULL_LEN[mode]);
            assign term[gi] = codeword[gi] ? h_col(mode, gi) : '0;
        end
    endgenerate

    always_comb begin
        s = '0;
        for (int i = 0; i < CW_WIDTH; i++)
            s = s ^ term[i];
    end

    assign p = ^(codeword & live);

endmodule

// File: rtl/dec_stream.sv
// Two-stage streaming SEC-DED decoder with per-word mode and saturating error counters.
module dec_stream
    import ecc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_WIDTH          = 16
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    num_of_errors,
    output logic [5:0]                    err_pos,
    input  logic                          clear_cnt,
    output logic [CNT_WIDTH-1:0]          cnt_single,
    output logic [CNT_WIDTH-1:0]          cnt_double,
    output logic [CNT_WIDTH-1:0]          cnt_illegal
);

    logic                          s1_valid_reg;
    logic [MAX_CODEWORD_WIDTH-1:0] s1_data_reg;
    mode_e                         s1_mode_reg;
    logic [SYN_WIDTH-1:0]          syn;
    logic                          par;
    logic                          s2_adv;
    logic                          out_xfer;
    err_class_e                    cls_next;
    logic [POS_WIDTH-1:0]          pos_next;
    logic [MAX_CODEWORD_WIDTH-1:0] fixed_next;
    logic [MAX_INFO_WIDTH-1:0]     info_next;

    // S2 is full exactly when out_valid is set, so S1 advances whenever S2 does.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid_reg || s2_adv;
    assign out_xfer = out_valid && out_ready;

    dec_syndrome u_syndrome (
        .codeword (s1_data_reg),
        .mode     (s1_mode_reg),
        .s        (syn),
        .p        (par)
    );

    always_comb begin
        pos_next = '0;
        for (int i = 1; i < CW_WIDTH; i++)
            if (i < FULL_LEN[s1_mode_reg] && h_col(s1_mode_reg, i) == syn)
                pos_next = POS_WIDTH'(i);

        if (s1_mode_reg == MODE_ILLEGAL)
            cls_next = CLS_ILLEGAL;
        else if (par)
            cls_next = CLS_SINGLE;
        else if (syn != '0)
            cls_next = CLS_DOUBLE;
        else
            cls_next = CLS_CLEAN;

        // A zero syndrome with odd parity leaves pos_next at 0, the overall parity bit.
        fixed_next = s1_data_reg;
        if (cls_next == CLS_SINGLE)
            fixed_next = s1_data_reg ^ (MAX_CODEWORD_WIDTH'(1) << pos_next);

        info_next = MAX_INFO_WIDTH'((fixed_next >> PAR_LEN[s1_mode_reg]) &
                    ((MAX_CODEWORD_WIDTH'(1) << INFO_LEN[s1_mode_reg]) - MAX_CODEWORD_WIDTH'(1)));
        if (cls_next == CLS_ILLEGAL)
            info_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_data_reg   <= '0;
            s1_mode_reg   <= MODE_8_4;
            out_valid     <= 1'b0;
            data_out      <= '0;
            num_of_errors <= '0;
            err_pos       <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_data_reg <= data_in;
                    s1_mode_reg <= mode_e'(mod);
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid_reg;
                if (s1_valid_reg) begin
                    data_out      <= info_next;
                    num_of_errors <= cls_next;
                    err_pos       <= (cls_next == CLS_SINGLE) ? pos_next : '0;
                end
            end
        end
    end

    // Counter gi tracks class gi+1; clear has priority over a same-cycle increment.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg <= '0;
                else if (clear_cnt)
                    cnt_reg <= '0;
                else if (out_xfer && num_of_errors == 2'(gi + 1) && cnt_reg != '1)
                    cnt_reg <= cnt_reg + 1'b1;
            end
        end
    endgenerate

    assign cnt_single  = g_cnt[0].cnt_reg;
    assign cnt_double  = g_cnt[1].cnt_reg;
    assign cnt_illegal = g_cnt[2].cnt_reg;

endmodule

// File: tb/tb_dec_stream.sv
// Directed bench for dec_stream: vector table, clean stream, backpressure, counter and reset corners.
module tb_dec_stream;

    localparam int CW = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [1:0]  mod;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] data_out;
    logic [1:0]  num_of_errors;
    logic [5:0]  err_pos;
    logic        clear_cnt;
    logic [CW-1:0] cnt_single;
    logic [CW-1:0] cnt_double;
    logic [CW-1:0] cnt_illegal;

    dec_stream #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_in       (data_in),
        .mod           (mod),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_out      (data_out),
        .num_of_errors (num_of_errors),
        .err_pos       (err_pos),
        .clear_cnt     (clear_cnt),
        .cnt_single    (cnt_single),
        .cnt_double    (cnt_double),
        .cnt_illegal   (cnt_illegal)
    );

    typedef struct {
        logic [1:0]  m;
        logic [31:0] din;
        logic [25:0] exp_d;
        logic [1:0]  exp_n;
        logic [5:0]  exp_p;
    } vec_t;

    typedef struct {
        logic [25:0] d;
        logic [1:0]  n;
        logic [5:0]  p;
        int          cyc;
    } exp_t;

    vec_t  tbl [11];
    exp_t  expq [$];
    exp_t  mon_e;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    stalls = 0;
    bit    lat_chk = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] bcol(input int k);
        logic [4:0] r;
        int c;
        r = '0;
        c = 0;
        for (int v = 3; v < 32; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (c == k) r = 5'(v);
                c++;
            end
        end
        return r;
    endfunction

    function automatic int bpar(input logic [1:0] m);
        return (m == 2'd0) ? 4 : (m == 2'd1) ? 5 : 6;
    endfunction

    function automatic int binfo(input logic [1:0] m);
        return (m == 2'd0) ? 4 : (m == 2'd1) ? 11 : 26;
    endfunction

    // Reference encoder: check bit j sits at index j+1, overall parity at index 0.
    function automatic logic [31:0] enc(input logic [1:0] m, input logic [25:0] info);
        int p;
        int n;
        logic [4:0]  s;
        logic [31:0] cw;
        p  = bpar(m);
        n  = binfo(m);
        s  = '0;
        cw = '0;
        for (int k = 0; k < n; k++)
            if (info[k]) begin
                cw[p + k] = 1'b1;
                s = s ^ bcol(k);
            end
        for (int j = 0; j < p - 1; j++)
            cw[j + 1] = s[j];
        cw[0] = ^cw;
        return cw;
    endfunction

    task automatic send(input logic [1:0] m, input logic [31:0] d,
                        input logic [25:0] ed, input logic [1:0] en, input logic [5:0] ep);
        bit   done;
        exp_t e;
        done     = 1'b0;
        in_valid = 1'b1;
        mod      = m;
        data_in  = d;
        for (int w = 0; w < 50 && !done; w++) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = ed; e.n = en; e.p = ep; e.cyc = cyc;
                expq.push_back(e);
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", {31'd0, done}, 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (expq.size() == 0 && !out_valid) done = 1'b1;
        end
        chk("drain_done", {31'd0, done}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got data=%0h cls=%0d, expected no word", data_out, num_of_errors);
            end else begin
                mon_e = expq.pop_front();
                $display("out cyc=%0d data=%07h cls=%0d pos=%0d", cyc, data_out, num_of_errors, err_pos);
                chk("out_data", 32'(data_out), 32'(mon_e.d));
                chk("out_class", 32'(num_of_errors), 32'(mon_e.n));
                chk("out_pos", 32'(err_pos), 32'(mon_e.p));
                if (lat_chk) chk("latency", cyc - mon_e.cyc, 32'd2);
            end
        end
    end

    initial begin
        logic [1:0]  m;
        logic [25:0] info;
        logic [31:0] d;
        int          acc;
        bit          found;
        logic [CW-1:0] cs0;
        vec_t        bw [3];

        tbl[0]  = '{2'd0, 32'h0000_0085, 26'h000000A, 2'd1, 6'd5};
        tbl[1]  = '{2'd2, enc(2'd2, 26'h3FFFFFF) ^ 32'h8000_0000, 26'h3FFFFFF, 2'd1, 6'd31};
        tbl[2]  = '{2'd1, enc(2'd1, 26'h5A5) ^ 32'h0000_0208, 26'h00005B5, 2'd2, 6'd0};
        tbl[3]  = '{2'd3, 32'hDEAD_BEEF, 26'h0, 2'd3, 6'd0};
        tbl[4]  = '{2'd0, 32'h0000_00A5, 26'h000000A, 2'd0, 6'd0};
        tbl[5]  = '{2'd0, 32'h0000_00A4, 26'h000000A, 2'd1, 6'd0};
        tbl[6]  = '{2'd1, enc(2'd1, 26'h123) ^ 32'h0000_0004, 26'h0000123, 2'd1, 6'd2};
        tbl[7]  = '{2'd2, enc(2'd2, 26'h1234567) ^ 32'h0000_0400, 26'h1234567, 2'd1, 6'd10};
        tbl[8]  = '{2'd0, 32'hFFFF_FFA5, 26'h000000A, 2'd0, 6'd0};
        tbl[9]  = '{2'd2, enc(2'd2, 26'h0ABCDEF) ^ 32'h0010_0001, 26'h0AB8DEF, 2'd2, 6'd0};
        tbl[10] = '{2'd1, enc(2'd1, 26'h7FF), 26'h00007FF, 2'd0, 6'd0};

        bw[0] = '{2'd0, 32'h0000_0085, 26'h000000A, 2'd1, 6'd5};
        bw[1] = '{2'd1, enc(2'd1, 26'h0F0) ^ 32'h0000_0080, 26'h00000F0, 2'd1, 6'd7};
        bw[2] = '{2'd2, enc(2'd2, 26'h2AAAAAA) ^ 32'h0000_0040, 26'h2AAAAAA, 2'd1, 6'd6};

        rst = 1'b1; in_valid = 1'b0; data_in = '0; mod = '0; out_ready = 1'b0; clear_cnt = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_class", 32'(num_of_errors), 32'd0);
        chk("rst_err_pos", 32'(err_pos), 32'd0);
        chk("rst_cnt_single", 32'(cnt_single), 32'd0);
        chk("rst_cnt_double", 32'(cnt_double), 32'd0);
        chk("rst_cnt_illegal", 32'(cnt_illegal), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Clean words in all modes, garbage in unused MSBs, back to back.
        lat_chk = 1'b1;
        stalls  = 0;
        for (int i = 0; i < 100; i++) begin
            m    = 2'(i % 3);
            info = 26'($urandom) & 26'((32'd1 << binfo(m)) - 1);
            d    = enc(m, info);
            if (m == 2'd0) d = d | ($urandom << 8);
            if (m == 2'd1) d = d | ($urandom << 16);
            send(m, d, info, 2'd0, 6'd0);
        end
        drain();
        chk("clean_no_stalls", stalls, 32'd0);
        chk("clean_cnt_single", 32'(cnt_single), 32'd0);
        chk("clean_cnt_double", 32'(cnt_double), 32'd0);
        chk("clean_cnt_illegal", 32'(cnt_illegal), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            if (i == 2) begin
                drain();
                chk("cnt_single_after_two", 32'(cnt_single), 32'd2);
                @(posedge clk);
                #1;
            end
            send(tbl[i].m, tbl[i].din, tbl[i].exp_d, tbl[i].exp_n, tbl[i].exp_p);
        end
        drain();
        chk("tbl_cnt_single", 32'(cnt_single), 32'd5);
        chk("tbl_cnt_double", 32'(cnt_double), 32'd2);
        chk("tbl_cnt_illegal", 32'(cnt_illegal), 32'd1);
        lat_chk = 1'b0;

        // Backpressure: 5 stalled cycles with a word always offered.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        cs0 = cnt_single;
        acc = 0;
        in_valid = 1'b1;
        mod = bw[0].m;
        data_in = bw[0].din;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready && acc < 3) begin
                mon_e.d = bw[acc].exp_d; mon_e.n = bw[acc].exp_n; mon_e.p = bw[acc].exp_p; mon_e.cyc = cyc;
                expq.push_back(mon_e);
                acc++;
            end
            @(posedge clk);
            #1;
            if (acc < 3) begin
                mod = bw[acc].m;
                data_in = bw[acc].din;
            end
        end
        @(negedge clk);
        chk("bp_accepted", acc, 32'd2);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_data", 32'(data_out), 32'h0A);
        chk("bp_hold_class", 32'(num_of_errors), 32'd1);
        chk("bp_hold_pos", 32'(err_pos), 32'd5);
        chk("bp_cnt_frozen", 32'(cnt_single), 32'(cs0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        send(bw[2].m, bw[2].din, bw[2].exp_d, bw[2].exp_n, bw[2].exp_p);
        drain();
        chk("bp_cnt_after", 32'(cnt_single), 32'(cs0) + 32'd3);

        // Saturation of the 4-bit single-error counter.
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++)
            send(2'd0, 32'h0000_0085, 26'h000000A, 2'd1, 6'd5);
        drain();
        chk("sat_cnt_single", 32'(cnt_single), 32'd15);
        chk("sat_cnt_double", 32'(cnt_double), 32'd2);

        // clear_cnt coinciding with a single-error output transfer.
        @(posedge clk);
        #1;
        send(2'd0, 32'h0000_0085, 26'h000000A, 2'd1, 6'd5);
        found = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        clear_cnt = 1'b1;
        @(posedge clk);
        #1;
        clear_cnt = 1'b0;
        chk("clr_found_output", {31'd0, found}, 32'd1);
        chk("clr_cnt_single", 32'(cnt_single), 32'd0);
        chk("clr_cnt_double", 32'(cnt_double), 32'd0);
        chk("clr_cnt_illegal", 32'(cnt_illegal), 32'd0);
        send(2'd0, 32'h0000_0085, 26'h000000A, 2'd1, 6'd5);
        drain();
        chk("post_clr_count", 32'(cnt_single), 32'd1);

        // Reset with two words in flight.
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        send(tbl[2].m, tbl[2].din, tbl[2].exp_d, tbl[2].exp_n, tbl[2].exp_p);
        send(tbl[3].m, tbl[3].din, tbl[3].exp_d, tbl[3].exp_n, tbl[3].exp_p);
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data_out", 32'(data_out), 32'd0);
        chk("mid_rst_class", 32'(num_of_errors), 32'd0);
        chk("mid_rst_cnt_single", 32'(cnt_single), 32'd0);
        expq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) @(negedge clk);
        chk("post_rst_no_ghost", {31'd0, out_valid}, 32'd0);
        chk("post_rst_cnt_double", 32'(cnt_double), 32'd0);
        chk("post_rst_cnt_illegal", 32'(cnt_illegal), 32'd0);
        chk("queue_empty", expq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
